mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- CPU-side initiator for the word-only data memory port (12-bit byte address, 32-bit write data, write strobe, combinational 32-bit read).
- Sits between the execute stage and data memory and implements MIPS lb/lbu/lh/lhu/lw/sb/sh/sw.
- Sub-word stores are done as read-modify-write, because the memory has no byte enables.
- Uses a valid/ready request handshake and a single-cycle done/err response.

Parameters:
- ADDR_W, 12, width of the memory byte address driven on mem_pos. Word index is mem_pos[ADDR_W-1:2].

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request (state IDLE).
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  input  32  byte address; only [ADDR_W-1:0] used.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_done  output  1  one-cycle pulse marking request completion.
- resp_err  output  1  valid with resp_done; misaligned or reserved size.
- resp_rdata  output  32  load result, extended; holds value until next load completes.
- mem_pos  output  ADDR_W  byte address to data memory.
- mem_data  output  32  write data to data memory.
- mem_wr  output  1  memory write strobe; memory writes on posedge when high.
- mem_rdata  input  32  combinational read data from memory at mem_pos.

Behaviour:
- Byte lanes are little-endian: byte k of a word = bits [8k+7:8k], k = addr[1:0]. Halfword h = addr[1] selects bits [16h+15:16h].
- Reset (async): state=IDLE; req_ready=1; resp_done=0; resp_err=0; resp_rdata=0; mem_wr=0; mem_pos=0; mem_data=0. Internal address, data and op registers are cleared.
- mem_wr is decoded from state only, so asserting rst mid-operation drops it immediately. An in-flight RMW is abandoned with no partial write and no resp_done.
- States: IDLE, ACCESS, MERGE_WR, DONE.
- IDLE:
  - req_ready=1.
  - When req_valid=1, latch addr, wdata, write, size, signed.
  - Check alignment. Error cases: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0. On error, go to DONE with err flag set and no memory access.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_pos = latched addr.
  - Load: extract lane from mem_rdata, extend per signed, register into resp_rdata. Go to DONE.
  - Store word: mem_data = wdata, mem_wr=1 (write occurs at this edge). Go to DONE.
  - Store byte/half: merge wdata lane into the mem_rdata word and register the result. mem_wr=0. Go to MERGE_WR.
- MERGE_WR: mem_pos held, mem_data = merged word, mem_wr=1. Go to DONE.
- DONE: resp_done=1 for exactly one cycle, resp_err = latched err flag. Go to IDLE; req_ready=1 again the following cycle.
- Latency from accept edge to resp_done high:
  - Load / sw: 2 cycles.
  - sb/sh: 3 cycles.
  - Error: 1 cycle.
- Throughput: no new request is accepted while not in IDLE. req_valid outside IDLE is ignored; the requester must hold it.
- A failed (err) load leaves resp_rdata unchanged. A failed store never asserts mem_wr.
- mem_pos and mem_data hold their last value in IDLE/DONE. mem_wr=0 in IDLE, DONE, and load ACCESS.
- Address wrap: bits above ADDR_W-1 are ignored, so 0x1004 and 0x0004 hit the same word.

Test Plan:
- Reset mid-RMW: issue sb, assert rst during ACCESS -> mem_wr never high, memory word unchanged, outputs at reset values, req_ready=1 after release.
- sw then lw: sw addr 0x010 data 0xDEADBEEF -> mem_wr high for 1 cycle with mem_pos=0x010; then lw 0x010 -> resp_rdata=0xDEADBEEF, resp_done 2 cycles after accept, resp_err=0.
- Sub-word loads on word 0x80FF7F01 at 0x020:
  - lb 0x023 -> 0xFFFFFF80
  - lbu 0x023 -> 0x00000080
  - lh 0x022 -> 0xFFFF80FF
  - lhu 0x020 -> 0x00007F01
- RMW stores on word 0x11223344 at 0x030:
  - sb 0x031 data 0xAA -> mem_wr once, in MERGE_WR, writing 0x1122AA44; done 3 cycles after accept.
  - then sh 0x032 data 0xBEEF -> word becomes 0xBEEFAA44.
- Misaligned: lw 0x041, lh 0x043, size=11 -> each gives resp_done+resp_err 1 cycle after accept, mem_wr stays 0, resp_rdata unchanged.
- Back-to-back: hold req_valid with two requests -> second accepted only on the cycle after resp_done; exactly one resp_done pulse per request.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory initiator for MIPS byte/half/word loads and stores.
// Sub-word stores use read-modify-write since the memory has no byte enables.
module mem_access_unit #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_done,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_pos,
  output logic [31:0]       mem_data,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q, mem_pos_q;
  logic [31:0]       wdata_q, mem_data_q, rdata_q;
  logic              write_q, signed_q, err_q;
  logic [1:0]        size_q;
  logic              accept, req_err;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       ld_val, st_merged;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:ADDR_W];
  assign accept         = (state == IDLE) && req_valid;

  always_comb begin
    req_err = 1'b0;
    case (req_size)
      2'b01:   req_err = req_addr[0];
      2'b10:   req_err = (req_addr[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  // Lane extraction for loads and lane insertion for sub-word stores
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      2'd3:    ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_val = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_val = mem_rdata;
    endcase

    st_merged = mem_rdata;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd1:    st_merged[15:8]  = wdata_q[7:0];
        2'd2:    st_merged[23:16] = wdata_q[7:0];
        2'd3:    st_merged[31:24] = wdata_q[7:0];
        default: st_merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      st_merged[31:16] = wdata_q[15:0];
    end else begin
      st_merged[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    resp_done = 1'b0;
    resp_err  = 1'b0;
    mem_wr    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_err ? DONE : ACCESS;
      end
      ACCESS: begin
        if (write_q && size_q != 2'b10) begin
          state_nxt = MERGE_WR;
        end else begin
          mem_wr    = write_q;
          state_nxt = DONE;
        end
      end
      MERGE_WR: begin
        mem_wr    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        resp_done = 1'b1;
        resp_err  = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // mem_pos/mem_data only move on a valid accept so an error leaves the bus untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      err_q      <= 1'b0;
      mem_pos_q  <= '0;
      mem_data_q <= '0;
      rdata_q    <= '0;
    end else begin
      if (accept) begin
        addr_q   <= req_addr[ADDR_W-1:0];
        wdata_q  <= req_wdata;
        write_q  <= req_write;
        size_q   <= req_size;
        signed_q <= req_signed;
        err_q    <= req_err;
        if (!req_err) begin
          mem_pos_q <= req_addr[ADDR_W-1:0];
          if (req_write && req_size == 2'b10) mem_data_q <= req_wdata;
        end
      end
      if (state == ACCESS) begin
        if (!write_q)              rdata_q    <= ld_val;
        else if (size_q != 2'b10)  mem_data_q <= st_merged;
      end
    end
  end

  assign mem_pos    = mem_pos_q;
  assign mem_data   = mem_data_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model and a response scoreboard.
module tb_mem_access_unit;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready, req_write, req_signed;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;
  logic              resp_done, resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_pos;
  logic [31:0]       mem_data, mem_rdata;
  logic              mem_wr;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_done(resp_done), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_pos(mem_pos), .mem_data(mem_data),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_val;

  assign mem_rdata = mem[mem_pos[11:2]];
  always @(posedge clk) begin
    if (mem_wr)      mem[mem_pos[11:2]] <= mem_data;
    else if (pre_we) mem[pre_idx] <= pre_val;
  end

  typedef struct {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t              sb_q[$];
  exp_t              mon_e;
  int                n_cmp = 0;
  int                n_bad = 0;
  int                wr_cnt = 0;
  logic [ADDR_W-1:0] last_wr_pos = '0;
  logic [31:0]       model_rd = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (mem_wr === 1'b1) begin
      wr_cnt++;
      last_wr_pos = mem_pos;
    end
    if (resp_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(resp_done), 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check("resp_err", 32'(resp_err), 32'(mon_e.err));
        check("resp_rdata", resp_rdata, mon_e.rd);
      end
    end
  end

  task automatic preload(input logic [31:0] byte_addr, input logic [31:0] val);
    @(negedge clk);
    pre_we  = 1'b1;
    pre_idx = byte_addr[11:2];
    pre_val = val;
    @(negedge clk);
    pre_we  = 1'b0;
  endtask

  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic exp_err,
                        input logic [31:0] exp_rd, input int exp_lat, input int exp_wr);
    int  lat;
    int  wr0;
    bit  got;
    if (!wr && !exp_err) model_rd = exp_rd;
    sb_q.push_back('{exp_err, model_rd});
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_ready"}, 32'(got), 32'd1);
    @(posedge clk);
    wr0 = wr_cnt;
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (resp_done !== 1'b1 && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(resp_done), 32'd0);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
    check({tag, "_wr_count"}, 32'(wr_cnt - wr0), 32'(exp_wr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [5:0]    exp_done_seq;
    bit [5:0]    exp_ready_seq;
    int          wr0;

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    #2;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_done", 32'(resp_done), 32'd0);
    check("rst_err", 32'(resp_err), 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_pos", 32'(mem_pos), 32'd0);
    check("rst_mem_data", mem_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_req("sw_010", 1'b1, 2'b10, 1'b0, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1);
    check("sw_pos", 32'(last_wr_pos), 32'h010);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    do_req("lw_010", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 1'b0, 32'hDEADBEEF, 2, 0);

    preload(32'h020, 32'h80FF7F01);
    do_req("lb_023",  1'b0, 2'b00, 1'b1, 32'h023, 32'h0, 1'b0, 32'hFFFFFF80, 2, 0);
    do_req("lbu_023", 1'b0, 2'b00, 1'b0, 32'h023, 32'h0, 1'b0, 32'h00000080, 2, 0);
    do_req("lh_022",  1'b0, 2'b01, 1'b1, 32'h022, 32'h0, 1'b0, 32'hFFFF80FF, 2, 0);
    do_req("lhu_020", 1'b0, 2'b01, 1'b0, 32'h020, 32'h0, 1'b0, 32'h00007F01, 2, 0);
    do_req("lb_021",  1'b0, 2'b00, 1'b1, 32'h021, 32'h0, 1'b0, 32'h0000007F, 2, 0);

    preload(32'h030, 32'h11223344);
    do_req("sb_031", 1'b1, 2'b00, 1'b0, 32'h031, 32'h000000AA, 1'b0, 32'h0, 3, 1);
    check("sb_mem", mem[12], 32'h1122AA44);
    check("sb_pos", 32'(last_wr_pos), 32'h031);
    do_req("sh_032", 1'b1, 2'b01, 1'b0, 32'h032, 32'h0000BEEF, 1'b0, 32'h0, 3, 1);
    check("sh_mem", mem[12], 32'hBEEFAA44);

    do_req("lw_wrap", 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 1'b0, 32'hDEADBEEF, 2, 0);

    do_req("lw_041_mis", 1'b0, 2'b10, 1'b0, 32'h041, 32'h0, 1'b1, 32'h0, 1, 0);
    do_req("lh_043_mis", 1'b0, 2'b01, 1'b1, 32'h043, 32'h0, 1'b1, 32'h0, 1, 0);
    do_req("sz11_st",    1'b1, 2'b11, 1'b0, 32'h040, 32'h12345678, 1'b1, 32'h0, 1, 0);
    do_req("sw_mis",     1'b1, 2'b10, 1'b0, 32'h032, 32'h12345678, 1'b1, 32'h0, 1, 0);
    check("mis_mem", mem[12], 32'hBEEFAA44);

    // Two requests with req_valid held high throughout
    exp_done_seq  = 6'b010010;
    exp_ready_seq = 6'b100100;
    sb_q.push_back('{1'b0, 32'hDEADBEEF});
    sb_q.push_back('{1'b0, 32'h80FF7F01});
    model_rd = 32'h80FF7F01;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h010; req_wdata = '0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("b2b_done_%0d", k), 32'(resp_done), 32'(exp_done_seq[k]));
      check($sformatf("b2b_ready_%0d", k), 32'(req_ready), 32'(exp_ready_seq[k]));
      if (k == 0) req_addr = 32'h020;
      if (k == 3) req_valid = 1'b0;
    end
    check("b2b_drained", 32'(sb_q.size()), 32'd0);

    // Reset while a byte store sits in ACCESS
    preload(32'h050, 32'h55667788);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h051; req_wdata = 32'h00000099;
    @(posedge clk);
    wr0 = wr_cnt;
    #1;
    req_valid = 1'b0;
    check("rmw_access_wr", 32'(mem_wr), 32'd0);
    check("rmw_access_ready", 32'(req_ready), 32'd0);
    #1;
    rst = 1'b1;
    #1;
    check("rmw_rst_wr", 32'(mem_wr), 32'd0);
    check("rmw_rst_ready", 32'(req_ready), 32'd1);
    check("rmw_rst_done", 32'(resp_done), 32'd0);
    check("rmw_rst_rdata", resp_rdata, 32'd0);
    check("rmw_rst_pos", 32'(mem_pos), 32'd0);
    check("rmw_rst_data", mem_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_rd = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rmw_post_ready", 32'(req_ready), 32'd1);
    check("rmw_post_done", 32'(resp_done), 32'd0);
    check("rmw_mem_kept", mem[20], 32'h55667788);
    check("rmw_no_write", 32'(wr_cnt - wr0), 32'd0);

    do_req("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h030, 32'h0, 1'b0, 32'hBEEFAA44, 2, 0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
